// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: frames scan codes, tracks E0/F0 prefixes and
// presents the held mapped key as an 8-bit HID usage on keycode.
module ps2_keycode_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StDecode} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   parity_q;
  logic [TmoW-1:0]        tmo_q;
  logic                   e0_seen_q;
  logic                   f0_seen_q;

  logic       clk_s;
  logic       data_s;
  logic       fall;
  logic       tmo_hit;
  logic       map_hit;
  logic [7:0] map_hid;

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign fall    = ~clk_s & clk_prev_q;
  assign tmo_hit = (tmo_q == TmoLast);

  // Extended codes are only ever matched against the E0 half of the table.
  always_comb begin
    map_hit = 1'b1;
    map_hid = 8'h00;
    unique case ({e0_seen_q, shift_q})
      9'h01D:  map_hid = 8'h1A;
      9'h01C:  map_hid = 8'h04;
      9'h01B:  map_hid = 8'h16;
      9'h023:  map_hid = 8'h07;
      9'h029:  map_hid = 8'h2C;
      9'h05A:  map_hid = 8'h28;
      9'h076:  map_hid = 8'h29;
      9'h175:  map_hid = 8'h52;
      9'h172:  map_hid = 8'h51;
      9'h16B:  map_hid = 8'h50;
      9'h174:  map_hid = 8'h4F;
      default: map_hit = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      e0_seen_q   <= 1'b0;
      f0_seen_q   <= 1'b0;
      keycode     <= 8'h00;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;

      if (state_q inside {StData, StParity, StStop}) begin
        tmo_q <= fall ? '0 : tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (fall) begin
            if (!data_s) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        StData, StParity, StStop: begin
          if (fall) begin
            if (state_q == StData) begin
              shift_q   <= {data_s, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= StParity;
            end else if (state_q == StParity) begin
              parity_q <= data_s;
              state_q  <= StStop;
            end else if (data_s && (^{shift_q, parity_q})) begin
              state_q <= StDecode;
            end else begin
              frame_err <= 1'b1;
              e0_seen_q <= 1'b0;
              f0_seen_q <= 1'b0;
              state_q   <= StIdle;
            end
          end else if (tmo_hit) begin
            // Keyboard stalled mid-frame: drop the partial byte and any prefix.
            frame_err <= 1'b1;
            e0_seen_q <= 1'b0;
            f0_seen_q <= 1'b0;
            shift_q   <= '0;
            state_q   <= StIdle;
          end
        end
        StDecode: begin
          if (shift_q == 8'hE0) begin
            e0_seen_q <= 1'b1;
          end else if (shift_q == 8'hF0) begin
            f0_seen_q <= 1'b1;
          end else begin
            if (map_hit) begin
              key_valid <= 1'b1;
              if (!f0_seen_q) begin
                keycode <= map_hid;
              end else if (map_hid == keycode) begin
                keycode <= 8'h00;
              end
            end
            e0_seen_q <= 1'b0;
            f0_seen_q <= 1'b0;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: bit-level PS/2 frames against a key-event
// model that predicts each key_valid / frame_err pulse and the held keycode.
module tb_ps2_keycode_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 100;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode_rx #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] kc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur_ev;
  int         total     = 0;
  int         bad       = 0;
  logic [7:0] mdl_kc    = 8'h00;  // keycode the DUT should show right now
  logic [7:0] mdl_pred  = 8'h00;  // keycode after every queued event lands
  bit         m_e0      = 1'b0;
  bit         m_f0      = 1'b0;
  int         cyc       = 0;
  int         stop_cyc  = 0;
  int         kv_cyc    = 0;
  int         kv_count  = 0;
  int         err_count = 0;

  // {extended, set-2 code} -> HID usage
  logic [8:0] map_code[11] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h029, 9'h05A, 9'h076,
                               9'h175, 9'h172, 9'h16B, 9'h174};
  logic [7:0] map_hid[11]  = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h28, 8'h29,
                               8'h52, 8'h51, 8'h50, 8'h4F};

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (key_valid || frame_err) begin
        if (key_valid) begin
          kv_count++;
          kv_cyc = cyc;
        end
        if (frame_err) err_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, key_valid, frame_err}, 32'd0);
        end else begin
          cur_ev = exp_q.pop_front();
          chk("event_kind", {30'd0, key_valid, frame_err}, cur_ev.is_err ? 32'd1 : 32'd2);
          if (!cur_ev.is_err) mdl_kc = cur_ev.kc;
        end
      end
      chk("keycode", {24'd0, keycode}, {24'd0, mdl_kc});
    end
  end

  task automatic mdl_byte(input logic [7:0] b);
    logic [7:0] hid = 8'h00;
    bit         hit = 1'b0;
    if (b == 8'hE0) begin
      m_e0 = 1'b1;
    end else if (b == 8'hF0) begin
      m_f0 = 1'b1;
    end else begin
      for (int i = 0; i < 11; i++) begin
        if (map_code[i] == {m_e0, b}) begin
          hit = 1'b1;
          hid = map_hid[i];
        end
      end
      if (hit) begin
        if (!m_f0) mdl_pred = hid;
        else if (hid == mdl_pred) mdl_pred = 8'h00;
        exp_q.push_back(ev_t'{is_err: 1'b0, kc: mdl_pred});
      end
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end
  endtask

  task automatic push_err();
    exp_q.push_back(ev_t'{is_err: 1'b1, kc: mdl_pred});
    m_e0 = 1'b0;
    m_f0 = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input bit mark);
    @(negedge Clk) ps2_data = b;
    repeat (5) @(negedge Clk);
    ps2_clk = 1'b0;
    if (mark) stop_cyc = cyc;
    repeat (10) @(negedge Clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
    if (flip_par || bad_stop) push_err();
    else mdl_byte(b);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0);
    drive_bit((~^b) ^ flip_par, 1'b0);
    drive_bit(~bad_stop, 1'b1);
    ps2_data = 1'b1;
    repeat (20) @(negedge Clk);
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int e0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;

    // Idle lines after reset
    repeat (10000) @(negedge Clk);
    chk("idle_kc", {24'd0, keycode}, 32'h00);
    chk("idle_pulses", kv_count + err_count, 32'd0);

    // D make with exact latency from the stop edge
    k0 = kv_count;
    send(8'h23);
    chk("d_make_kc", {24'd0, keycode}, 32'h07);
    chk("d_make_pulses", kv_count - k0, 32'd1);
    chk("d_make_latency", kv_cyc - stop_cyc, SYNC + 2);

    // Last-pressed wins, break of held key, break of other key
    send(8'h1D);
    chk("w_make_kc", {24'd0, keycode}, 32'h1A);
    send(8'hF0);
    send(8'h1D);
    chk("w_break_kc", {24'd0, keycode}, 32'h00);
    k0 = kv_count;
    send(8'hF0);
    send(8'h23);
    chk("d_break_kc", {24'd0, keycode}, 32'h00);
    chk("d_break_pulses", kv_count - k0, 32'd1);

    // Extended Left make/break, then bare 0x6B is unmapped
    send(8'hE0);
    send(8'h6B);
    chk("left_make_kc", {24'd0, keycode}, 32'h50);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("left_break_kc", {24'd0, keycode}, 32'h00);
    send(8'h29);
    k0 = kv_count;
    send(8'h6B);
    chk("bare_6b_kc", {24'd0, keycode}, 32'h2C);
    chk("bare_6b_pulses", kv_count - k0, 32'd0);

    // Parity and stop errors
    e0 = err_count;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("parity_err", err_count - e0, 32'd1);
    chk("parity_err_kc", {24'd0, keycode}, 32'h2C);
    e0 = err_count;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("stop_err", err_count - e0, 32'd1);
    send(8'h1C);
    chk("a_make_kc", {24'd0, keycode}, 32'h04);

    // Timeout after start + 4 data bits
    e0 = err_count;
    push_err();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    repeat (200) @(negedge Clk);
    chk("timeout_err", err_count - e0, 32'd1);
    chk("timeout_drain", exp_q.size(), 32'd0);
    send(8'h29);
    chk("space_kc", {24'd0, keycode}, 32'h2C);

    // Reset mid-frame
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    @(negedge Clk);
    Reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    exp_q.delete();
    mdl_kc   = 8'h00;
    mdl_pred = 8'h00;
    m_e0     = 1'b0;
    m_f0     = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    chk("reset_kc", {24'd0, keycode}, 32'h00);
    send(8'h1B);
    chk("s_make_kc", {24'd0, keycode}, 32'h16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- Keyboard front end: receives PS/2 set-2 scan-code frames from the keyboard and drives the game's 8-bit `keycode` bus in HID usage form (e.g. 0x07 = D, 0x1A = W).
- This block is the producer of `keycode`; game logic (`top_level_pball` path) consumes it.
- Tracks make/break/extended prefixes and holds the code of the currently pressed mapped key.
- Returns `keycode` to 0x00 on that key's release.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchronizers on `ps2_clk` and `ps2_data`; legal range 2–4.
- TIMEOUT_CYCLES, 50000: `Clk` cycles without a `ps2_clk` falling edge before an in-progress frame is aborted; 1 ms at 50 MHz.

Ports:
- Clk, input, 1: system clock, 50 MHz.
- Reset, input, 1: synchronous, active-high reset.
- ps2_clk, input, 1: asynchronous PS/2 clock from the keyboard; idles high.
- ps2_data, input, 1: asynchronous PS/2 data from the keyboard; idles high.
- keycode, output, 8: HID usage of the currently held mapped key; 0x00 when none is held.
- key_valid, output, 1: one-cycle pulse for each accepted mapped make or break event.
- frame_err, output, 1: one-cycle pulse on a parity, stop, start or timeout error.

Behaviour:
- Reset (synchronous, active-high; also mid-frame):
  - `keycode` = 0x00, `key_valid` = 0, `frame_err` = 0.
  - FSM returns to IDLE; shift register, bit counter, timeout counter, `e0_seen` and `f0_seen` are all cleared.
  - Synchronizer flops load 1.
- Input sampling:
  - Both inputs pass through SYNC_STAGES flops.
  - A falling edge is synchronized `ps2_clk` = 0 while its previous-cycle value = 1.
  - Synchronized `ps2_data` is sampled only on a falling-edge cycle.
- Frame format: 11 bits — start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM states and transitions:
  - IDLE: on an edge with data = 0, go to DATA and clear the counter. On an edge with data = 1, pulse `frame_err` and stay in IDLE.
  - DATA: shift data into bit [7] and shift right; after the 8th data edge go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP: on the stop edge, check stop = 1 and XOR(data, parity) = 1.
    - Pass: go to DECODE for exactly 1 cycle.
    - Fail: pulse `frame_err`, clear both prefix flags, go to IDLE.
  - DECODE:
    - byte 0xE0: set `e0_seen`.
    - byte 0xF0: set `f0_seen`.
    - Any other byte: look it up in the map with the `e0_seen` qualifier, act on it, then clear both flags.
    - Always return to IDLE.
- Timeout:
  - The counter runs in DATA, PARITY and STOP and resets on every falling edge.
  - On reaching TIMEOUT_CYCLES−1: pulse `frame_err`, clear both flags, go to IDLE, discard the partial byte.
  - The counter is held at 0 in IDLE.
- Map, non-extended (set-2 → HID):
  - 0x1D → 0x1A (W)
  - 0x1C → 0x04 (A)
  - 0x1B → 0x16 (S)
  - 0x23 → 0x07 (D)
  - 0x29 → 0x2C (Space)
  - 0x5A → 0x28 (Enter)
  - 0x76 → 0x29 (Esc)
- Map, extended (E0-prefixed):
  - 0x75 → 0x52 (Up)
  - 0x72 → 0x51 (Down)
  - 0x6B → 0x50 (Left)
  - 0x74 → 0x4F (Right)
  - An E0-prefixed code is never matched against the non-extended table.
- Unmapped codes: no output change, no `key_valid` pulse; flags are still cleared.
- Make of a mapped key (`f0_seen` = 0):
  - `keycode` ← HID value and `key_valid` pulses.
  - Typematic repeat of the same make: `keycode` unchanged, `key_valid` still pulses.
  - A new make overrides a held key (last-pressed wins).
- Break of a mapped key (`f0_seen` = 1):
  - HID equals current `keycode`: `keycode` ← 0x00 and `key_valid` pulses.
  - HID differs from current `keycode`: `keycode` unchanged, `key_valid` still pulses.
- Latency:
  - Stop-bit edge detected on cycle N; DECODE on N+1.
  - `keycode` and `key_valid` are registered and visible on N+2.
  - `frame_err` for a STOP failure is visible on N+1.
- Simultaneous Reset and edge: Reset wins.
- Outputs are registered only; no combinational path from the inputs.

Test Plan:
- Reset for 4 cycles, then idle lines for 10k cycles → `keycode` = 0x00; `key_valid` and `frame_err` never assert.
- Frame 0x23 (D make, parity 0) → `keycode` = 0x07 two cycles after the stop edge; exactly one `key_valid` pulse.
- D make, then frames 0x1D, 0xF0, 0x1D, then 0xF0, 0x23 → `keycode` goes 0x07 → 0x1A → 0x00. The final 0xF0, 0x23 leaves 0x00 and pulses `key_valid` once.
- Frames 0xE0, 0x6B, then 0xE0, 0xF0, 0x6B → `keycode` 0x50, then 0x00; a bare 0x6B (no E0) afterwards leaves `keycode` unchanged.
- Frame 0x1C with a flipped parity bit, and separately with stop = 0 → one `frame_err` pulse each; `keycode` unchanged. The next valid 0x1C sets `keycode` = 0x04.
- Drive start + 4 data bits, then hold `ps2_clk` high (TIMEOUT_CYCLES = 100) → `frame_err` pulses about 100 cycles after the last edge; a following full 0x29 frame gives `keycode` = 0x2C. Asserting Reset mid-frame also clears `keycode` to 0x00.
